// File: rtl/md_unit_pkg.sv
// md_defs: shared op/state encodings and latency helper for the multiply/divide unit
package md_defs;
   typedef enum logic [2:0] {
      MD_MULT  = 3'd0,
      MD_MULTU = 3'd1,
      MD_DIV   = 3'd2,
      MD_DIVU  = 3'd3,
      MD_MADD  = 3'd4,
      MD_MADDU = 3'd5,
      MD_MSUB  = 3'd6,
      MD_MSUBU = 3'd7
   } md_op_e;
   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} md_state_e;
   function automatic int md_latency(md_op_e op, int mult_cycles, int div_cycles);
      return (op == MD_DIV || op == MD_DIVU) ? div_cycles : mult_cycles;
   endfunction
endpackage

// File: rtl/md_result_calc.sv
// md_result_calc: combinational multiply/accumulate/divide result for one md_unit launch
module md_result_calc
   import md_defs::*;
#(
   parameter int WIDTH = 32
) (
   input  md_op_e             op,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic [2*WIDTH-1:0] acc,
   output logic [2*WIDTH-1:0] result,
   output logic               div_by_zero
);
   logic               sgn, is_div, na, nb;
   logic [2*WIDTH-1:0] ae, be, prod;
   logic [WIDTH-1:0]   ma, mb, dv, q, r, quo, rem;
   // Sign-extending to 2*WIDTH makes one unsigned multiply serve both signednesses
   assign sgn    = ~op[0];
   assign is_div = (op == MD_DIV) || (op == MD_DIVU);
   assign ae     = {{WIDTH{sgn & a[WIDTH-1]}}, a};
   assign be     = {{WIDTH{sgn & b[WIDTH-1]}}, b};
   assign prod   = ae * be;
   assign na     = sgn & a[WIDTH-1];
   assign nb     = sgn & b[WIDTH-1];
   assign ma     = na ? -a : a;
   assign mb     = nb ? -b : b;
   assign dv     = (mb == '0) ? WIDTH'(1) : mb;
   assign q      = ma / dv;
   assign r      = ma % dv;
   assign quo    = (na ^ nb) ? -q : q;
   assign rem    = na ? -r : r;
   assign result = is_div ? {rem, quo} : op[2] ? (op[1] ? acc - prod : acc + prod) : prod;
   assign div_by_zero = is_div && (b == '0);
endmodule

// File: rtl/md_unit.sv
// md_unit: E-stage multiply/divide unit owning HI/LO, with configurable latency and cancel
module md_unit
   import md_defs::*;
#(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic [2:0]       Op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             HiWrite,
   input  logic             LoWrite,
   input  logic [WIDTH-1:0] WData,
   input  logic             Cancel,
   output logic             Busy,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO
);
   localparam int MAXL = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = $clog2(MAXL + 1);
   md_state_e          state;
   logic [CW-1:0]      cnt, load;
   logic [2*WIDTH-1:0] pend, res;
   logic               dbz, calc_dbz;
   md_result_calc #(.WIDTH(WIDTH)) u_calc (
      .op          (md_op_e'(Op)),
      .a           (A),
      .b           (B),
      .acc         ({HI, LO}),
      .result      (res),
      .div_by_zero (calc_dbz)
   );
   assign load = CW'(md_latency(md_op_e'(Op), MULT_CYCLES, DIV_CYCLES) - 1);
   assign Busy = (state == RUN);
   // Result is computed once at launch; the countdown only models latency
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state <= IDLE;
         cnt   <= '0;
         pend  <= '0;
         dbz   <= 1'b0;
         HI    <= '0;
         LO    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (!Cancel && Start) begin
                  pend  <= res;
                  dbz   <= calc_dbz;
                  cnt   <= load;
                  state <= RUN;
               end else if (!Cancel) begin
                  if (HiWrite) HI <= WData;
                  if (LoWrite) LO <= WData;
               end
            end
            RUN: begin
               if (Cancel) state <= IDLE;
               else if (cnt == '0) begin
                  if (!dbz) {HI, LO} <= pend;
                  state <= IDLE;
               end else cnt <= cnt - 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end
   // mthi/mtlo while an op is in flight is dropped; the hazard unit must prevent it
   always_ff @(posedge Clk) begin
      if (Reset && state == RUN) assert (!(HiWrite || LoWrite));
   end
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: table-driven check of md_unit at default latency and at single-cycle latency
module tb_md_unit;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0, hi_write = 1'b0, lo_write = 1'b0, cancel = 1'b0;
   logic [2:0]  op = 3'd0;
   logic [31:0] a = '0, b = '0, wdata = '0;
   logic        busy0, busy1;
   logic [31:0] hi0, lo0, hi1, lo1;
   int checks = 0, errors = 0;
   int bc0, bc1;

   always #5 clk = ~clk;

   md_unit dut0 (
      .Clk(clk), .Reset(reset), .Start(start), .Op(op), .A(a), .B(b),
      .HiWrite(hi_write), .LoWrite(lo_write), .WData(wdata), .Cancel(cancel),
      .Busy(busy0), .HI(hi0), .LO(lo0)
   );
   md_unit #(.WIDTH(32), .MULT_CYCLES(1), .DIV_CYCLES(1)) dut1 (
      .Clk(clk), .Reset(reset), .Start(start), .Op(op), .A(a), .B(b),
      .HiWrite(hi_write), .LoWrite(lo_write), .WData(wdata), .Cancel(cancel),
      .Busy(busy1), .HI(hi1), .LO(lo1)
   );

   typedef struct {
      string       name;
      logic [2:0]  op;
      logic [31:0] a, b, pre_hi, pre_lo, hi, lo;
   } vec_t;
   vec_t vt[13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic mt(input logic [31:0] h, input logic [31:0] l);
      @(negedge clk); hi_write = 1'b1; wdata = h;
      @(posedge clk); #1 hi_write = 1'b0;
      @(negedge clk); lo_write = 1'b1; wdata = l;
      @(posedge clk); #1 lo_write = 1'b0;
   endtask

   task automatic launch(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      @(negedge clk); start = 1'b1; op = o; a = x; b = y;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      bit done = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         if (busy0) bc0++;
         if (busy1) bc1++;
         if (!busy0 && !busy1) done = 1'b1;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL %s timeout: busy0=%b busy1=%b still high after 40 cycles", name, busy0, busy1);
      end
   endtask

   initial begin
      vt[0]  = '{"mult_neg",   3'd0, 32'hFFFFFFFD, 32'd5,        32'h0,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFF1};
      vt[1]  = '{"multu",      3'd1, 32'hFFFFFFFD, 32'd5,        32'h0,        32'h0,        32'h00000004, 32'hFFFFFFF1};
      vt[2]  = '{"div_neg",    3'd2, 32'hFFFFFFF9, 32'd2,        32'h0,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFD};
      vt[3]  = '{"divu",       3'd3, 32'd7,        32'd2,        32'h0,        32'h0,        32'h00000001, 32'h00000003};
      vt[4]  = '{"div_zero",   3'd2, 32'd9,        32'd0,        32'h11,       32'h22,       32'h00000011, 32'h00000022};
      vt[5]  = '{"madd",       3'd4, 32'd2,        32'd3,        32'h0,        32'd10,       32'h00000000, 32'd16};
      vt[6]  = '{"msub",       3'd6, 32'd4,        32'd5,        32'h0,        32'd16,       32'hFFFFFFFF, 32'hFFFFFFFC};
      vt[7]  = '{"div_minneg", 3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h0,        32'h00000000, 32'h80000000};
      vt[8]  = '{"maddu",      3'd5, 32'hFFFFFFFF, 32'd2,        32'h0,        32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFD};
      vt[9]  = '{"msubu",      3'd7, 32'd1,        32'd1,        32'h0,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF};
      vt[10] = '{"div_negdiv", 3'd2, 32'd7,        32'hFFFFFFFE, 32'h0,        32'h0,        32'h00000001, 32'hFFFFFFFD};
      vt[11] = '{"madd_neg",   3'd4, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
      vt[12] = '{"divu_zero",  3'd3, 32'd5,        32'd0,        32'h5,        32'h6,        32'h00000005, 32'h00000006};

      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      chk("reset_busy0", 32'(busy0), 32'd0);
      chk("reset_hi0", hi0, 32'h0);
      chk("reset_lo0", lo0, 32'h0);
      chk("reset_busy1", 32'(busy1), 32'd0);

      foreach (vt[i]) begin
         mt(vt[i].pre_hi, vt[i].pre_lo);
         launch(vt[i].op, vt[i].a, vt[i].b);
         bc0 = 0; bc1 = 0;
         wait_idle(vt[i].name);
         chk({vt[i].name, "_busy0"}, bc0, (vt[i].op == 3'd2 || vt[i].op == 3'd3) ? 10 : 5);
         chk({vt[i].name, "_busy1"}, bc1, 1);
         chk({vt[i].name, "_hi0"}, hi0, vt[i].hi);
         chk({vt[i].name, "_lo0"}, lo0, vt[i].lo);
         chk({vt[i].name, "_hi1"}, hi1, vt[i].hi);
         chk({vt[i].name, "_lo1"}, lo1, vt[i].lo);
      end

      // Reset three cycles into a divide
      mt(32'h11, 32'h22);
      launch(3'd2, 32'd100, 32'd7);
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk); #1 reset = 1'b1;
      @(negedge clk);
      chk("midrst_busy0", 32'(busy0), 32'd0);
      chk("midrst_hi0", hi0, 32'h0);
      chk("midrst_lo0", lo0, 32'h0);
      chk("midrst_lo1", lo1, 32'h0);
      launch(3'd0, 32'd2, 32'd3);
      bc0 = 0; bc1 = 0;
      wait_idle("postrst");
      chk("postrst_lo0", lo0, 32'd6);
      chk("postrst_busy0", bc0, 5);

      // Cancel on the commit edge of dut0; dut1 has already committed
      mt(32'h0, 32'h1);
      launch(3'd0, 32'd7, 32'd7);
      repeat (4) @(posedge clk);
      #1 cancel = 1'b1;
      @(posedge clk); #1 cancel = 1'b0;
      @(negedge clk);
      chk("cancel_busy0", 32'(busy0), 32'd0);
      chk("cancel_lo0", lo0, 32'h1);
      chk("cancel_hi0", hi0, 32'h0);
      chk("cancel_lo1", lo1, 32'd49);

      // Start pulsed while dut0 busy: ignored by dut0, accepted by idle dut1
      launch(3'd0, 32'd3, 32'd3);
      bc0 = 0; bc1 = 0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         if (busy0) bc0++;
      end
      start = 1'b1; op = 3'd0; a = 32'd100; b = 32'd100;
      @(posedge clk); #1 start = 1'b0;
      wait_idle("restart");
      chk("restart_busy0", bc0, 5);
      chk("restart_lo0", lo0, 32'd9);
      chk("restart_lo1", lo1, 32'd10000);

      // Start and mtlo in the same idle cycle: start wins
      @(negedge clk);
      start = 1'b1; op = 3'd0; a = 32'd1; b = 32'd1; lo_write = 1'b1; wdata = 32'h55;
      @(posedge clk); #1 start = 1'b0; lo_write = 1'b0;
      bc0 = 0; bc1 = 0;
      wait_idle("start_mt");
      chk("start_mt_lo0", lo0, 32'd1);
      chk("start_mt_lo1", lo1, 32'd1);
      chk("start_mt_busy0", bc0, 5);

      // Cancel in idle suppresses both start and mthi
      @(negedge clk);
      cancel = 1'b1; start = 1'b1; hi_write = 1'b1; wdata = 32'hAB; op = 3'd0; a = 32'd9; b = 32'd9;
      @(posedge clk); #1 cancel = 1'b0; start = 1'b0; hi_write = 1'b0;
      @(negedge clk);
      chk("idlecancel_busy0", 32'(busy0), 32'd0);
      chk("idlecancel_busy1", 32'(busy1), 32'd0);
      chk("idlecancel_hi0", hi0, 32'h0);
      chk("idlecancel_lo0", lo0, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
